// File: rtl/ahb_lite_sram_ws_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and transfer decode helpers
// for the wait-state SRAM slave.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Alignment and ROM-write legality of an address-phase transfer.
    function automatic logic is_legal(input logic [2:0] size, input logic [1:0] addr,
                                      input logic write, input logic rom);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr[0];
            HSIZE_WORD: ok = (addr == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok & ~(write & rom);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << addr;
            HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_lite_sram_ws_if.sv
// AHB-Lite slave-side bus bundle; the decoder/master drives the master modport.
interface ahb_lite_sram_ws_if;

    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb_lite_sram_ws_core.sv
// Word-wide synchronous RAM with byte write enables and a registered read port.
// Write and read addresses are separate so a commit and a new read share one edge.
module ahb_sram_core #(
    parameter int AW        = 12,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    localparam int DEPTH = 2 ** AW;

    logic [31:0] mem_q [0:DEPTH-1];
    logic [31:0] rdata_q;

    // Array has no reset: contents survive a bus reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    // Read-before-write: a same-address write on this edge is merged by the caller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rdata_q <= 32'h0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_lite_sram_ws.sv
// AHB-Lite SRAM slave: programmable wait states, ROM mode, two-cycle ERROR,
// and same-edge write-to-read forwarding into HRDATA.
module ahb_lite_sram_ws
    import ahb_lite_pkg::*;
#(
    parameter int MEMWIDTH    = 14,
    parameter int WAIT_STATES = 0,
    parameter int ROM_MODE    = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic HCLK,
    input  logic HRESETn,
    ahb_lite_sram_ws_if.slave bus
);

    localparam int AW       = MEMWIDTH - 2;
    localparam int WS_FIRST = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [2:0] WS_LOAD = 3'(WS_FIRST);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          wr_q;
    logic [AW-1:0] widx_q;
    logic [3:0]    lanes_q;
    logic [3:0]    fwd_mask_q;
    logic [31:0]   fwd_data_q;

    logic          acc, legal, rd_acc, commit, fwd_hit;
    logic [AW-1:0] idx_in;
    logic [3:0]    lanes_in;
    logic [31:0]   core_rdata;
    logic [31:0]   fwd_bits;
    logic          unused_addr;

    assign acc      = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign legal    = is_legal(bus.HSIZE, bus.HADDR[1:0], bus.HWRITE, ROM_MODE != 0);
    assign idx_in   = bus.HADDR[MEMWIDTH-1:2];
    assign lanes_in = lane_mask(bus.HSIZE, bus.HADDR[1:0]);
    assign rd_acc   = acc & legal & ~bus.HWRITE;
    assign commit   = (state_q == ST_DATA) & wr_q;
    assign fwd_hit  = commit & (widx_q == idx_in);

    assign unused_addr = ^{bus.HADDR[31:MEMWIDTH], bus.HTRANS[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // IDLE, DATA and ERR2 all end with HREADYOUT=1, so each can accept the next transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 3'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (acc) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_comb begin
        bus.HREADYOUT = ~((state_q == ST_WAIT) | (state_q == ST_ERR1));
        bus.HRESP     = ((state_q == ST_ERR1) | (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    // Address-phase capture; an illegal write never arms the commit.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q    <= 1'b0;
            widx_q  <= '0;
            lanes_q <= 4'b0;
        end else if (acc) begin
            wr_q    <= bus.HWRITE & legal;
            widx_q  <= idx_in;
            lanes_q <= lanes_in;
        end else if (commit) begin
            wr_q    <= 1'b0;
        end
    end

    // Forwarding state only moves on a read sample so HRDATA holds between reads.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fwd_mask_q <= 4'b0;
            fwd_data_q <= 32'h0;
        end else if (rd_acc) begin
            fwd_mask_q <= fwd_hit ? lanes_q : 4'b0;
            fwd_data_q <= bus.HWDATA;
        end
    end

    ahb_sram_core #(
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .we_i    (commit ? lanes_q : 4'b0),
        .waddr_i (widx_q),
        .wdata_i (bus.HWDATA),
        .re_i    (rd_acc),
        .raddr_i (idx_in),
        .rdata_o (core_rdata)
    );

    always_comb begin
        fwd_bits = 32'h0;
        for (int b = 0; b < 4; b++) fwd_bits[8*b +: 8] = {8{fwd_mask_q[b]}};
    end

    assign bus.HRDATA = (core_rdata & ~fwd_bits) | (fwd_data_q & fwd_bits);

endmodule

// File: tb/tb_ahb_lite_sram_ws.sv
// Bench for ahb_lite_sram_ws: three slaves (WS=0, WS=3, ROM) on one muxed bus,
// table-driven pipelined transfers checked through an expected-result queue.
module tb_ahb_lite_sram_ws;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] hwdata = 32'h0;
    int          dsel = 0;

    logic        rdy_mux, resp_mux;
    logic [31:0] rdata_mux;

    ahb_lite_sram_ws_if if0 ();
    ahb_lite_sram_ws_if if1 ();
    ahb_lite_sram_ws_if if2 ();

    assign rdy_mux   = (dsel == 0) ? if0.HREADYOUT : (dsel == 1) ? if1.HREADYOUT : if2.HREADYOUT;
    assign resp_mux  = (dsel == 0) ? if0.HRESP     : (dsel == 1) ? if1.HRESP     : if2.HRESP;
    assign rdata_mux = (dsel == 0) ? if0.HRDATA    : (dsel == 1) ? if1.HRDATA    : if2.HRDATA;

    assign if0.HSEL = hsel && (dsel == 0);
    assign if1.HSEL = hsel && (dsel == 1);
    assign if2.HSEL = hsel && (dsel == 2);
    assign if0.HREADY = rdy_mux;  assign if1.HREADY = rdy_mux;  assign if2.HREADY = rdy_mux;
    assign if0.HADDR  = haddr;    assign if1.HADDR  = haddr;    assign if2.HADDR  = haddr;
    assign if0.HTRANS = htrans;   assign if1.HTRANS = htrans;   assign if2.HTRANS = htrans;
    assign if0.HWRITE = hwrite;   assign if1.HWRITE = hwrite;   assign if2.HWRITE = hwrite;
    assign if0.HSIZE  = hsize;    assign if1.HSIZE  = hsize;    assign if2.HSIZE  = hsize;
    assign if0.HWDATA = hwdata;   assign if1.HWDATA = hwdata;   assign if2.HWDATA = hwdata;

    ahb_lite_sram_ws #(.MEMWIDTH(14), .WAIT_STATES(0), .ROM_MODE(0), .INIT_FILE("")) u_ws0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(if0));
    ahb_lite_sram_ws #(.MEMWIDTH(14), .WAIT_STATES(3), .ROM_MODE(0), .INIT_FILE("")) u_ws3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(if1));
    ahb_lite_sram_ws #(.MEMWIDTH(14), .WAIT_STATES(0), .ROM_MODE(1), .INIT_FILE("")) u_rom (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(if2));

    typedef struct {
        int          dut;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
        logic        chk;    // compare HRDATA
        logic        err;
        int          gap;    // idle cycles before this address phase
    } vec_t;

    typedef struct {
        int          id;
        logic        chk;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   ws_of[3] = '{0, 3, 0};

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic add(input int dut, input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] data, input logic chk, input logic err, input int gap);
        vec_t v;
        v.dut = dut; v.wr = wr; v.sz = sz; v.addr = addr;
        v.data = data; v.chk = chk; v.err = err; v.gap = gap;
        vecs.push_back(v);
    endtask

    // Sample the data phase at negedges until HREADYOUT, then step past the ending edge.
    task automatic finish_dphase();
        exp_t e;
        int   stalls = 0;
        logic done = 1'b0;
        logic resp_ok = 1'b1;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_empty got=0 exp=1");
            return;
        end
        e = sb.pop_front();
        while (!done) begin
            @(negedge HCLK);
            if (rdy_mux) done = 1'b1;
            else begin
                stalls++;
                if (resp_mux !== e.err) resp_ok = 1'b0;
                if (stalls > 32) begin
                    tests++; fails++;
                    $display("FAIL v%0d.timeout got=%0d exp=%0d stalls", e.id, stalls, e.waits);
                    done = 1'b1;
                end
            end
        end
        check($sformatf("v%0d.waits", e.id), 32'(stalls), 32'(e.waits));
        check($sformatf("v%0d.resp", e.id), {31'b0, resp_mux}, {31'b0, e.err});
        if (stalls > 0) check($sformatf("v%0d.stall_resp", e.id), {31'b0, resp_ok}, 32'd1);
        if (e.chk) check($sformatf("v%0d.rdata", e.id), rdata_mux, e.rdata);
        @(posedge HCLK); #1;
    endtask

    task automatic run_vecs(input int first, input int last);
        int   cur = -1;
        exp_t e;
        for (int i = first; i <= last; i++) begin
            if (vecs[i].gap > 0) begin
                htrans = 2'b00;
                if (cur >= 0) begin finish_dphase(); cur = -1; end
                repeat (vecs[i].gap) begin @(posedge HCLK); #1; end
            end
            dsel   = vecs[i].dut;
            hsel   = 1'b1;
            htrans = 2'b10;
            hwrite = vecs[i].wr;
            hsize  = vecs[i].sz;
            haddr  = vecs[i].addr;
            e.id = i; e.chk = vecs[i].chk & ~vecs[i].wr; e.rdata = vecs[i].data;
            e.err = vecs[i].err; e.waits = vecs[i].err ? 1 : ws_of[vecs[i].dut];
            sb.push_back(e);
            if (cur >= 0) finish_dphase();
            else begin @(posedge HCLK); #1; end
            htrans = 2'b00;
            hwdata = vecs[i].wr ? vecs[i].data : 32'h0;
            cur = i;
        end
        htrans = 2'b00;
        if (cur >= 0) finish_dphase();
    endtask

    int post_rst_idx;

    initial begin
        // WS=0 slave
        add(0, 1, 3'b010, 32'h100,  32'hDEADBEEF, 0, 0, 1);
        add(0, 0, 3'b010, 32'h100,  32'hDEADBEEF, 1, 0, 1);
        add(0, 1, 3'b010, 32'h100,  32'h11223344, 0, 0, 1);
        add(0, 1, 3'b000, 32'h103,  32'hAA000000, 0, 0, 0);
        add(0, 0, 3'b010, 32'h100,  32'hAA223344, 1, 0, 1);
        add(0, 1, 3'b001, 32'h102,  32'h55660000, 0, 0, 0);
        add(0, 0, 3'b010, 32'h100,  32'h55663344, 1, 0, 1);
        add(0, 1, 3'b010, 32'h200,  32'hCAFEF00D, 0, 0, 0);
        add(0, 0, 3'b010, 32'h200,  32'hCAFEF00D, 1, 0, 0);
        add(0, 1, 3'b000, 32'h201,  32'h00007700, 0, 0, 0);
        add(0, 0, 3'b010, 32'h200,  32'hCAFE770D, 1, 0, 0);
        add(0, 0, 3'b000, 32'h203,  32'hCAFE770D, 1, 0, 1);
        add(0, 0, 3'b010, 32'h102,  32'h0,        0, 1, 0);
        add(0, 1, 3'b011, 32'h100,  32'hFFFFFFFF, 0, 1, 0);
        add(0, 0, 3'b010, 32'h100,  32'h55663344, 1, 0, 0);
        add(0, 1, 3'b001, 32'h101,  32'hFFFFFFFF, 0, 1, 0);
        add(0, 0, 3'b010, 32'h4100, 32'h55663344, 1, 0, 1);
        add(0, 1, 3'b010, 32'h300,  32'h33333333, 0, 0, 0);
        add(0, 0, 3'b010, 32'h100,  32'h55663344, 1, 0, 0);
        add(0, 1, 3'b010, 32'h3FFC, 32'h0BADF00D, 0, 0, 0);
        add(0, 0, 3'b010, 32'h7FFC, 32'h0BADF00D, 1, 0, 1);
        // WS=3 slave
        add(1, 1, 3'b010, 32'h40,   32'h12345678, 0, 0, 2);
        add(1, 0, 3'b010, 32'h40,   32'h12345678, 1, 0, 1);
        add(1, 1, 3'b010, 32'h44,   32'hA5A5A5A5, 0, 0, 0);
        add(1, 0, 3'b010, 32'h44,   32'hA5A5A5A5, 1, 0, 0);
        add(1, 0, 3'b001, 32'h43,   32'h0,        0, 1, 0);
        add(1, 1, 3'b010, 32'h80,   32'h11111111, 0, 0, 0);
        // ROM slave
        add(2, 1, 3'b010, 32'h10,   32'h12345678, 0, 1, 2);
        add(2, 1, 3'b000, 32'h11,   32'h000000FF, 0, 1, 0);
        add(2, 0, 3'b011, 32'h10,   32'h0,        0, 1, 0);
        add(2, 0, 3'b010, 32'h102,  32'h0,        0, 1, 0);
        add(2, 0, 3'b010, 32'h10,   32'h0,        0, 0, 0);
        post_rst_idx = vecs.size();
        add(1, 0, 3'b010, 32'h80,   32'h11111111, 1, 0, 1);

        repeat (2) @(posedge HCLK);
        #1;
        check("rst_ready", {29'b0, if2.HREADYOUT, if1.HREADYOUT, if0.HREADYOUT}, 32'h7);
        check("rst_resp",  {29'b0, if2.HRESP, if1.HRESP, if0.HRESP}, 32'h0);
        check("rst_rdata0", if0.HRDATA, 32'h0);
        check("rst_rdata1", if1.HRDATA, 32'h0);
        @(negedge HCLK); HRESETn = 1'b1;
        @(posedge HCLK); #1;

        run_vecs(0, post_rst_idx - 1);

        // Reset during the second wait cycle of a write to 0x80 on the WS=3 slave.
        dsel = 1; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'h80;
        @(posedge HCLK); #1;
        htrans = 2'b00; hwdata = 32'h22222222;
        @(negedge HCLK);
        check("ws_stall_ready", {31'b0, rdy_mux}, 32'h0);
        @(posedge HCLK); #1;
        check("pre_rst_rdata", rdata_mux, 32'hA5A5A5A5);
        HRESETn = 1'b0;
        #1;
        check("midrst_ready", {31'b0, rdy_mux}, 32'h1);
        check("midrst_resp",  {31'b0, resp_mux}, 32'h0);
        check("midrst_rdata", rdata_mux, 32'h0);
        @(negedge HCLK); HRESETn = 1'b1;
        @(posedge HCLK); #1;
        run_vecs(post_rst_idx, post_rst_idx);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
